// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, reset PC, bubble encoding,
// base opcodes (shared with the control unit) and the IF/ID payload type.
package core_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned ILEN     = 32;

    localparam logic [XLEN-1:0] RESET_PC  = XLEN'(32'h0000_0000);
    // addi x0,x0,0: decodes as I_type writing x0, so it has no architectural effect
    localparam logic [ILEN-1:0] NOP_INSTR = ILEN'(32'h0000_0013);

    localparam logic [6:0] OP_LW     = 7'b000_0011;
    localparam logic [6:0] OP_SW     = 7'b010_0011;
    localparam logic [6:0] OP_R_TYPE = 7'b011_0011;
    localparam logic [6:0] OP_I_TYPE = 7'b001_0011;
    localparam logic [6:0] OP_JAL    = 7'b110_1111;
    localparam logic [6:0] OP_BEQ    = 7'b110_0011;
    localparam logic [6:0] OP_JALR   = 7'b110_0111;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        instr:    NOP_INSTR,
        pc:       '0,
        pc_plus4: '0,
        valid:    1'b0
    };

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   imem_addr  : fetch address (driven by fetch stage, master)
//   imem_rdata : instruction word, combinational, same cycle (memory, slave)
//   imem_ready : imem_rdata valid this cycle (memory, slave)
interface fetch_stage_if;
    import core_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [ILEN-1:0] imem_rdata;
    logic            imem_ready;

    modport master (output imem_addr, input  imem_rdata, input  imem_ready);
    modport slave  (input  imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with flush > stall > bubble-on-not-ready priority.
//   clk, rst      : clock, synchronous active-high reset
//   flush_i       : squash to bubble (beats stall_i)
//   stall_i       : hold current contents
//   fetch_ok_i    : fetched word valid this cycle; otherwise load a bubble
//   payload_i     : fetched instruction, its PC and PC+4
//   payload_o     : registered IF/ID contents
module if_id_reg
    import core_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   flush_i,
    input  logic   stall_i,
    input  logic   fetch_ok_i,
    input  if_id_t payload_i,
    output if_id_t payload_o
);

    if_id_t ifid_q;
    if_id_t ifid_d;

    // Next-state selection
    always_comb begin
        ifid_d = ifid_q;
        if (flush_i) begin
            ifid_d = IF_ID_BUBBLE;
        end else if (stall_i) begin
            ifid_d = ifid_q;
        end else if (!fetch_ok_i) begin
            ifid_d = IF_ID_BUBBLE;
        end else begin
            ifid_d = payload_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_q <= IF_ID_BUBBLE;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign payload_o = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, drives the instruction-memory
// address and feeds the IF/ID register.
//   clk, rst     : clock, synchronous active-high reset
//   stall_f      : hold PC          stall_d : hold IF/ID
//   flush_d      : squash IF/ID     pc_src_e/pc_target_e : execute redirect
//   imem         : instruction-memory bus (master side)
//   instr_d, pc_d, pc_plus4_d, valid_d : registered IF/ID outputs
module fetch_stage
    import core_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_f,
    input  logic                stall_d,
    input  logic                flush_d,
    input  logic                pc_src_e,
    input  logic [XLEN-1:0]     pc_target_e,
    fetch_stage_if.master       imem,
    output logic [ILEN-1:0]     instr_d,
    output logic [XLEN-1:0]     pc_d,
    output logic [XLEN-1:0]     pc_plus4_d,
    output logic                valid_d
);

    logic [XLEN-1:0] pc_f_q;
    logic [XLEN-1:0] pc_f_d;
    logic [XLEN-1:0] pc_f_plus4;
    if_id_t          fetch_payload;
    if_id_t          ifid;

    assign pc_f_plus4 = pc_f_q + XLEN'(4);

    // Next-PC mux: redirect > hold (stall or memory not ready) > sequential
    always_comb begin
        pc_f_d = pc_f_q;
        if (pc_src_e) begin
            // jalr targets may have bit 0 set; it is dropped, never trapped
            pc_f_d = {pc_target_e[XLEN-1:1], 1'b0};
        end else if (stall_f || !imem.imem_ready) begin
            pc_f_d = pc_f_q;
        end else begin
            pc_f_d = pc_f_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_q <= RESET_PC;
        end else begin
            pc_f_q <= pc_f_d;
        end
    end

    assign imem.imem_addr = pc_f_q;

    always_comb begin
        fetch_payload          = IF_ID_BUBBLE;
        fetch_payload.instr    = imem.imem_rdata;
        fetch_payload.pc       = pc_f_q;
        fetch_payload.pc_plus4 = pc_f_plus4;
        fetch_payload.valid    = 1'b1;
    end

    // A redirect squashes the wrong-path fetch even without flush_d
    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_d | pc_src_e),
        .stall_i    (stall_d),
        .fetch_ok_i (imem.imem_ready),
        .payload_i  (fetch_payload),
        .payload_o  (ifid)
    );

    assign instr_d    = ifid.instr;
    assign pc_d       = ifid.pc;
    assign pc_plus4_d = ifid.pc_plus4;
    assign valid_d    = ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import core_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        mem_ready;

    fetch_stage_if imem ();

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .imem        (imem),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: every address holds a distinct, recognisable word
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[23:0], 8'h33};
    endfunction

    assign imem.imem_rdata = mem_word(imem.imem_addr);
    assign imem.imem_ready = mem_ready;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        int          step;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   fails  = 0;
    int   step_n = 0;
    bit   stim_done = 1'b0;

    // Apply one cycle of inputs and queue the state expected after the edge
    task automatic step(input logic r, input logic sf, input logic sd, input logic fd,
                        input logic src, input logic [31:0] tgt, input logic rdy,
                        input logic [31:0] e_addr, input logic [31:0] e_pc, input logic e_valid);
        exp_t e;
        @(negedge clk);
        rst = r; stall_f = sf; stall_d = sd; flush_d = fd;
        pc_src_e = src; pc_target_e = tgt; mem_ready = rdy;
        step_n++;
        e.addr  = e_addr;
        e.valid = e_valid;
        e.pc    = e_valid ? e_pc : 32'h0;
        e.pc4   = e_valid ? e_pc + 32'd4 : 32'h0;
        e.instr = e_valid ? mem_word(e_pc) : 32'h0000_0013;
        e.step  = step_n;
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry is consumed per clock edge
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (imem.imem_addr !== e.addr) begin
                    fails++;
                    $display("FAIL step%0d imem_addr: got %h expected %h", e.step, imem.imem_addr, e.addr);
                end
                tests++;
                if (valid_d !== e.valid || instr_d !== e.instr || pc_d !== e.pc || pc_plus4_d !== e.pc4) begin
                    fails++;
                    $display("FAIL step%0d if_id: got v=%b instr=%h pc=%h pc4=%h expected v=%b instr=%h pc=%h pc4=%h",
                             e.step, valid_d, instr_d, pc_d, pc_plus4_d, e.valid, e.instr, e.pc, e.pc4);
                end
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        pc_src_e = 1'b0; pc_target_e = 32'h0; mem_ready = 1'b1;
        //      rst  sf   sd   fd   src  target        rdy   addr          pc_d          valid
        step(1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h0,        32'h0,        1'b0); // reset
        step(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h4,        32'h0,        1'b1);
        step(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h8,        32'h4,        1'b1);
        step(1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        1'b1, 32'h8,        32'h4,        1'b1); // stall
        step(1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        1'b1, 32'h8,        32'h4,        1'b1);
        step(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'hC,        32'h8,        1'b1);
        step(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h10,       32'hC,        1'b1);
        step(1'b0,1'b1,1'b0,1'b0,1'b1,32'h101,      1'b1, 32'h100,      32'h0,        1'b0); // redirect beats stall_f
        step(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h104,      32'h100,      1'b1);
        step(1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1, 32'h108,      32'h0,        1'b0); // flush beats stall_d
        step(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h10C,      32'h108,      1'b1);
        step(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0, 32'h10C,      32'h0,        1'b0); // not ready x3
        step(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0, 32'h10C,      32'h0,        1'b0);
        step(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0, 32'h10C,      32'h0,        1'b0);
        step(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h110,      32'h10C,      1'b1);
        step(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h110,      32'h110,      1'b1); // stall_f only
        step(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h114,      32'h110,      1'b1);
        step(1'b0,1'b0,1'b0,1'b0,1'b1,32'h2F0,      1'b0, 32'h2F0,      32'h0,        1'b0); // redirect beats not-ready
        step(1'b0,1'b0,1'b1,1'b0,1'b1,32'hFFFF_FFFC,1'b1, 32'hFFFF_FFFC,32'h0,        1'b0); // redirect beats stall_d
        step(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h0,        32'hFFFF_FFFC,1'b1); // wrap
        step(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h4,        32'h0,        1'b1);
        step(1'b1,1'b1,1'b1,1'b0,1'b1,32'h200,      1'b1, 32'h0,        32'h0,        1'b0); // reset overrides all
        step(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h4,        32'h0,        1'b1);
        stim_done = 1'b1;
    end

    initial begin : finisher
        int budget;
        budget = 0;
        wait (stim_done);
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule
